seriallite3_tx_arbiter: RTL and testbench
=========================================

SERIALLITE3_TX_ARBITER -- requirements
Module: seriallite3_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters; fixed at 4 in this revision.
REQ-002 SHALL have parameter MAX_BURST, default 256, beat cap per burst; legal range 2..65535.
REQ-003 SHALL have port user_clock_tx, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port user_clock_reset_tx_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port req_data, input, 1024 bits: four 256-bit beats; requester i occupies bits [256*i+255:256*i].
REQ-006 SHALL have port req_valid, input, 4 bits: per-requester beat valid.
REQ-007 SHALL have port req_last, input, 4 bits: per-requester last beat of packet.
REQ-008 SHALL have port req_ready, output, 4 bits: per-requester beat accepted.
REQ-009 SHALL have port data_tx, output, 256 bits: to the SerialLite III TX data input.
REQ-010 SHALL have ports valid_tx, start_of_burst_tx and end_of_burst_tx, output, 1 bit each: to the SerialLite III TX inputs of the same name.
REQ-011 SHALL have port sync_tx, output, 8 bits: burst channel tag.
REQ-012 SHALL have ports ready_tx and link_up_tx, input, 1 bit each: from the SerialLite III core.
REQ-013 SHALL have port grant_id, output, 2 bits: current or last granted requester.
REQ-014 SHALL have port busy, output, 1 bit: high in state BURST.

Function
REQ-015 SHALL implement states IDLE and BURST, with a 2-bit grant register, a 2-bit rr_ptr and a 16-bit beat_cnt.
REQ-016 In IDLE, with link_up_tx=1 and req_valid!=0, it SHALL grant the first valid requester searching rr_ptr, rr_ptr+1, ... (mod 4), load grant, clear beat_cnt, and enter BURST on the next edge.
REQ-017 In IDLE with link_up_tx=0 or req_valid=0, it SHALL remain in IDLE.
REQ-018 In BURST, the outputs SHALL be combinational from the granted requester: data_tx=req_data[grant], valid_tx=req_valid[grant], req_ready[grant]=ready_tx.
REQ-019 All req_ready bits other than req_ready[grant] SHALL be 0. In IDLE, valid_tx SHALL be 0 and req_ready SHALL be 0.
REQ-020 A beat SHALL transfer when valid_tx && ready_tx; beat_cnt SHALL increment by 1 per transfer.
REQ-021 start_of_burst_tx SHALL equal valid_tx && (beat_cnt==0).
REQ-022 end_of_burst_tx SHALL equal valid_tx && (req_last[grant] || cap_hit), where cap_hit is defined in REQ-031.
REQ-023 sync_tx SHALL equal {6'b0, grant} while in BURST and 8'h00 in IDLE.
REQ-024 On a transfer with end_of_burst_tx=1, it SHALL set rr_ptr=grant+1 (mod 4) and return to IDLE. This gives one idle cycle between bursts, so arbitration latency is 1 cycle.
REQ-025 If link_up_tx falls while in BURST, it SHALL return to IDLE on the next edge. It SHALL NOT emit end_of_burst_tx, SHALL leave rr_ptr unchanged, and SHALL clear beat_cnt.
REQ-026 With valid_tx=1 and ready_tx=0, all outputs SHALL be held stable and beat_cnt SHALL not change.
REQ-027 beat_cnt SHALL NOT wrap; it is bounded by cap_hit or by req_last.

Reset
REQ-028 Asserting user_clock_reset_tx_n=0 SHALL immediately force state=IDLE, grant=0, rr_ptr=0 and beat_cnt=0, independent of the clock.
REQ-029 During reset, outputs SHALL be: valid_tx=0, start_of_burst_tx=0, end_of_burst_tx=0, req_ready=0, sync_tx=0, grant_id=0, busy=0, data_tx=0.
REQ-030 Reset asserted mid-burst SHALL abandon the burst with no end_of_burst_tx. After deassertion, arbitration SHALL restart from requester 0.

Configuration
REQ-031 With macro SL3_TX_ARB_BURST_CAP_EN defined, cap_hit SHALL equal (beat_cnt==MAX_BURST-1). The burst is forcibly ended and the requester rotated, and the requester's remaining beats start a new burst on a later grant.
REQ-032 With SL3_TX_ARB_BURST_CAP_EN undefined, cap_hit SHALL be 0 and bursts SHALL end only on req_last.

Verification
REQ-033 Single packet: link_up=1, req 2 sends 3 beats (last on beat 3), ready_tx=1 -> sync_tx=8'h02; SOB on beat 1; EOB on beat 3; then rr_ptr=3 and busy=0.
REQ-034 Round robin: all 4 requesters hold 1-beat packets continuously -> grant order 0,1,2,3,0, with one idle cycle between bursts.
REQ-035 Backpressure: ready_tx=0 for 5 cycles mid-burst -> data_tx, valid_tx and beat_cnt are frozen and no beat is lost or duplicated.
REQ-036 Link drop: link_up_tx falls after beat 2 of 4 -> IDLE next cycle, no EOB seen, req_ready=0, and the same requester is regranted first after the link recovers.
REQ-037 Cap (macro defined, MAX_BURST=4): a 10-beat packet from req 1 alone -> three bursts of 4, 4 and 2 beats, each with its own SOB and EOB.
REQ-038 Async reset pulsed mid-burst with no clock edge -> all outputs are 0 immediately, and the next grant goes to requester 0.

Source files
------------

// File: rtl/seriallite3_tx_arbiter.sv
// Four-requester round-robin burst arbiter feeding a SerialLite III TX user interface.
// Optional macro SL3_TX_ARB_BURST_CAP_EN: force end of burst after MAX_BURST beats.
module seriallite3_tx_arbiter #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned MAX_BURST = 256
) (
   input  logic                     user_clock_tx,
   input  logic                     user_clock_reset_tx_n,
   input  logic [256*NUM_REQ-1:0]   req_data,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ-1:0]       req_last,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [255:0]             data_tx,
   output logic                     valid_tx,
   output logic                     start_of_burst_tx,
   output logic                     end_of_burst_tx,
   output logic [7:0]               sync_tx,
   input  logic                     ready_tx,
   input  logic                     link_up_tx,
   output logic [1:0]               grant_id,
   output logic                     busy
);

`ifdef SL3_TX_ARB_BURST_CAP_EN
   localparam bit CAP_EN = 1'b1;
`else
   localparam bit CAP_EN = 1'b0;
`endif
   localparam logic [15:0] CAP_LAST = 16'(MAX_BURST - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [1:0]  r_grant, w_grant_nxt;
   logic [1:0]  r_rr_ptr, w_rr_ptr_nxt;
   logic [15:0] r_beat_cnt, w_beat_cnt_nxt;

   logic        w_in_burst;
   logic        w_cap_hit;
   logic        w_xfer;
   logic        w_found;
   logic [1:0]  w_pick;
   logic [1:0]  w_idx;

   // Round-robin search starting at rr_ptr
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_idx   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         w_idx = r_rr_ptr + 2'(i);
         if (!w_found && req_valid[w_idx]) begin
            w_found = 1'b1;
            w_pick  = w_idx;
         end
      end
   end

   // Outputs are masked while the link is down so a dropped link never shows EOB
   always_comb begin
      w_in_burst        = (r_state == BURST) && link_up_tx;
      w_cap_hit         = CAP_EN && (r_beat_cnt == CAP_LAST);
      valid_tx          = w_in_burst && req_valid[r_grant];
      req_ready         = '0;
      req_ready[r_grant] = w_in_burst && ready_tx;
      data_tx           = (r_state == BURST) ? req_data[256*r_grant +: 256] : '0;
      start_of_burst_tx = valid_tx && (r_beat_cnt == '0);
      end_of_burst_tx   = valid_tx && (req_last[r_grant] || w_cap_hit);
      sync_tx           = (r_state == BURST) ? {6'b0, r_grant} : 8'h00;
      grant_id          = r_grant;
      busy              = (r_state == BURST);
      w_xfer            = valid_tx && ready_tx;
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_grant_nxt    = r_grant;
      w_rr_ptr_nxt   = r_rr_ptr;
      w_beat_cnt_nxt = r_beat_cnt;
      unique case (r_state)
         IDLE: begin
            if (link_up_tx && w_found) begin
               w_state_nxt    = BURST;
               w_grant_nxt    = w_pick;
               w_beat_cnt_nxt = '0;
            end
         end
         BURST: begin
            if (!link_up_tx) begin
               w_state_nxt    = IDLE;
               w_beat_cnt_nxt = '0;
            end else if (w_xfer) begin
               if (end_of_burst_tx) begin
                  w_state_nxt    = IDLE;
                  w_rr_ptr_nxt   = r_grant + 2'd1;
                  w_beat_cnt_nxt = '0;
               end else if (r_beat_cnt != '1) begin
                  w_beat_cnt_nxt = r_beat_cnt + 16'd1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge user_clock_tx or negedge user_clock_reset_tx_n) begin
      if (!user_clock_reset_tx_n) begin
         r_state    <= IDLE;
         r_grant    <= '0;
         r_rr_ptr   <= '0;
         r_beat_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_grant    <= w_grant_nxt;
         r_rr_ptr   <= w_rr_ptr_nxt;
         r_beat_cnt <= w_beat_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_seriallite3_tx_arbiter.sv
// Scoreboard bench for seriallite3_tx_arbiter: drivers queue expected beats, a negedge monitor checks them.
module tb_seriallite3_tx_arbiter;

`ifdef SL3_TX_ARB_BURST_CAP_EN
   localparam bit CAP_EN = 1'b1;
`else
   localparam bit CAP_EN = 1'b0;
`endif
   localparam int MB = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1023:0] req_data = '0;
   logic [3:0]    req_valid = '0;
   logic [3:0]    req_last = '0;
   logic [3:0]    req_ready;
   logic [255:0]  data_tx;
   logic          valid_tx, sob, eob;
   logic [7:0]    sync_tx;
   logic          ready_tx = 1'b1;
   logic          link_up = 1'b1;
   logic [1:0]    grant_id;
   logic          busy;

   typedef struct {
      logic [255:0] data;
      logic         sob;
      logic         eob;
      logic [7:0]   sync;
   } beat_t;

   beat_t q[$];
   int    n_chk = 0;
   int    n_pass = 0;
   int    n_xfer = 0;
   bit    prev_eob = 1'b0;

   seriallite3_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(MB)) dut (
      .user_clock_tx(clk),
      .user_clock_reset_tx_n(rst_n),
      .req_data(req_data),
      .req_valid(req_valid),
      .req_last(req_last),
      .req_ready(req_ready),
      .data_tx(data_tx),
      .valid_tx(valid_tx),
      .start_of_burst_tx(sob),
      .end_of_burst_tx(eob),
      .sync_tx(sync_tx),
      .ready_tx(ready_tx),
      .link_up_tx(link_up),
      .grant_id(grant_id),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   function automatic logic [255:0] bdata(input int r, input int b);
      logic [255:0] d;
      d = '0;
      d[255:248] = 8'(r);
      d[247:240] = 8'(b);
      d[31:0]    = 32'hA5A5_0000 ^ 32'(r * 16 + b);
      return d;
   endfunction

   // Monitor: every accepted beat must match the head of the scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_eob) chk("idle_gap_busy", 256'(busy), 256'(0));
         prev_eob = valid_tx && ready_tx && eob;
         if (valid_tx && ready_tx) begin
            n_xfer++;
            if (q.size() == 0) begin
               chk("unexpected_beat", 256'(1), 256'(0));
            end else begin
               beat_t e;
               e = q.pop_front();
               chk("beat_data", data_tx, e.data);
               chk("beat_sync_sob_eob", 256'({sync_tx, sob, eob}), 256'({e.sync, e.sob, e.eob}));
            end
         end
      end else begin
         prev_eob = 1'b0;
      end
   end

   task automatic push_beat(input int r, input int b, input bit s, input bit e);
      beat_t x;
      x.data = bdata(r, b);
      x.sob  = s;
      x.eob  = e;
      x.sync = 8'(r);
      q.push_back(x);
   endtask

   // restart_at: beat index where the bench expects a fresh burst (after a link drop)
   task automatic send_pkt(input int r, input int n, input int restart_at, input bit do_push);
      int  idx;
      bit  last, e, ok;
      int  guard;
      idx = 0;
      if (do_push) begin
         for (int b = 0; b < n; b++) begin
            if (b == restart_at) idx = 0;
            last = (b == n - 1);
            e = last || (CAP_EN && idx == MB - 1);
            push_beat(r, b, idx == 0, e);
            idx = e ? 0 : idx + 1;
         end
      end
      for (int b = 0; b < n; b++) begin
         req_data[256*r +: 256] = bdata(r, b);
         req_valid[r] = 1'b1;
         req_last[r]  = (b == n - 1);
         guard = 0;
         forever begin
            @(negedge clk);
            ok = req_ready[r] && req_valid[r];
            @(posedge clk);
            #1;
            if (ok) break;
            guard++;
            if (guard > 200) begin
               chk("driver_timeout", 256'(1), 256'(0));
               break;
            end
         end
      end
      req_valid[r] = 1'b0;
      req_last[r]  = 1'b0;
   endtask

   task automatic wait_xfers(input int target);
      int guard;
      guard = 0;
      while (n_xfer < target && guard < 200) begin
         @(posedge clk);
         guard++;
      end
      if (n_xfer < target) chk("wait_xfers_timeout", 256'(n_xfer), 256'(target));
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_valid"}, 256'(valid_tx), 256'(0));
      chk({tag, "_sob_eob"}, 256'({sob, eob}), 256'(0));
      chk({tag, "_req_ready"}, 256'(req_ready), 256'(0));
      chk({tag, "_sync"}, 256'(sync_tx), 256'(0));
      chk({tag, "_grant_busy"}, 256'({grant_id, busy}), 256'(0));
      chk({tag, "_data"}, data_tx, 256'(0));
   endtask

   initial begin
      int base;
      // Reset state with requests pending
      req_valid = 4'hF;
      req_data  = {4{bdata(7, 7)}};
      #2;
      check_all_zero("reset");
      @(posedge clk); #1;
      check_all_zero("reset_clocked");
      req_valid = '0;
      req_data  = '0;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      // Single packet, req 2, three beats
      send_pkt(2, 3, -1, 1'b1);
      @(negedge clk);
      chk("single_busy_after", 256'(busy), 256'(0));

      // rr_ptr now 3: req 3 beats req 0
      push_beat(3, 0, 1'b1, 1'b1);
      push_beat(0, 0, 1'b1, 1'b1);
      fork
         send_pkt(0, 1, -1, 1'b0);
         send_pkt(3, 1, -1, 1'b0);
      join

      // Backpressure on req 1 after beat 2 of 4
      base = n_xfer;
      fork
         send_pkt(1, 4, -1, 1'b1);
         begin
            wait_xfers(base + 2);
            #1 ready_tx = 1'b0;
            for (int c = 0; c < 5; c++) begin
               @(negedge clk);
               chk("stall_data", data_tx, bdata(1, 2));
               chk("stall_valid_sob_eob", 256'({valid_tx, sob, eob}), 256'({1'b1, 1'b0, 1'b0}));
            end
            @(posedge clk); #1 ready_tx = 1'b1;
         end
      join

      // Link drop on req 0 after beat 2 of 4
      base = n_xfer;
      fork
         send_pkt(0, 4, 2, 1'b1);
         begin
            wait_xfers(base + 2);
            #1 link_up = 1'b0;
            @(negedge clk);
            chk("linkdrop_eob_ready", 256'({eob, valid_tx, req_ready}), 256'(0));
            repeat (3) begin
               @(negedge clk);
               chk("linkdrop_idle", 256'({busy, req_ready}), 256'(0));
            end
            @(posedge clk); #1 link_up = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("linkdrop_regrant", 256'({busy, grant_id}), 256'({1'b1, 2'd0}));
         end
      join

      // Ten-beat packet from req 1 (capped into 4/4/2 when the cap is built in)
      send_pkt(1, 10, -1, 1'b1);

      // Async reset mid-burst on req 3
      base = n_xfer;
      push_beat(3, 0, 1'b1, 1'b0);
      req_data[256*3 +: 256] = bdata(3, 0);
      req_last[3]  = 1'b0;
      req_valid[3] = 1'b1;
      wait_xfers(base + 1);
      #3 rst_n = 1'b0;
      #1;
      check_all_zero("midburst_reset");
      req_valid = '0;
      @(posedge clk); #2 rst_n = 1'b1;
      @(posedge clk); #1;

      // Round robin after reset: 0,1,2,3,0
      base = n_xfer;
      for (int i = 0; i < 5; i++) push_beat(i % 4, 0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) req_data[256*i +: 256] = bdata(i, 0);
      req_last  = 4'hF;
      req_valid = 4'hF;
      wait_xfers(base + 5);
      #1;
      req_valid = '0;
      req_last  = '0;

      begin
         int guard;
         guard = 0;
         while (q.size() != 0 && guard < 50) begin
            @(posedge clk);
            guard++;
         end
      end
      repeat (3) @(posedge clk);
      chk("queue_drained", 256'(q.size()), 256'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
